// File: rtl/atmega_eep_ctrl.sv
// ATmega-style EEPROM controller on the CPU I/O bus: EEAR/EEDR/EECR, EEMPE window, timed programming, EE_READY.
// Optional host load/save port is enabled by defining ATMEGA_EEP_HOST_PORT_EN.
module atmega_eep_ctrl #(
  parameter int unsigned BUS_ADDR_DATA_LEN = 16,
  parameter int unsigned EEARH_ADDR        = 0,
  parameter int unsigned EEARL_ADDR        = 1,
  parameter int unsigned EEDR_ADDR         = 2,
  parameter int unsigned EECR_ADDR         = 3,
  parameter int unsigned EEP_SIZE          = 1024,
  parameter int unsigned WRITE_CYCLES      = 64,
  parameter string       INIT_FILE         = "",
  localparam int unsigned AW               = $clog2(EEP_SIZE)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [BUS_ADDR_DATA_LEN-1:0] addr,
  input  logic                         wr,
  input  logic                         rd,
  input  logic [7:0]                   bus_in,
  output logic [7:0]                   bus_out,
  output logic                         int_out,
  output logic                         dirty,
  input  logic                         dirty_clr
`ifdef ATMEGA_EEP_HOST_PORT_EN
  ,
  input  logic [AW-1:0]                host_addr,
  input  logic                         host_we,
  input  logic                         host_re,
  input  logic [7:0]                   host_din,
  output logic [7:0]                   host_dout,
  output logic                         host_ack
`endif
);

  localparam int unsigned BW    = $clog2(WRITE_CYCLES + 1);
  localparam logic [7:0]  HMASK = 8'((16'd1 << (AW - 8)) - 16'd1);

  typedef enum logic [1:0] {IDLE, PROG, READ} state_t;
  state_t state, state_nx;

  logic [7:0]    eearh, eearl, eedr;
  logic          eere, eepe, eempe, eerie;
  logic [1:0]    eepm;
  logic [2:0]    mpe_cnt;
  logic [BW-1:0] busy_cnt;
  logic          rd_done;
  logic [7:0]    mem [EEP_SIZE];
  logic [7:0]    mem_q, new_byte;
  logic [AW-1:0] eear;
  logic          wr_h, wr_l, wr_d, wr_c, prog_start, read_start, done;

  assign eear = AW'({eearh, eearl});
  assign wr_h = wr && (addr == BUS_ADDR_DATA_LEN'(EEARH_ADDR));
  assign wr_l = wr && (addr == BUS_ADDR_DATA_LEN'(EEARL_ADDR));
  assign wr_d = wr && (addr == BUS_ADDR_DATA_LEN'(EEDR_ADDR));
  assign wr_c = wr && (addr == BUS_ADDR_DATA_LEN'(EECR_ADDR));

  // Reserved mode 11 never starts a program; a valid program start suppresses EERE
  assign prog_start = wr_c && bus_in[1] && eempe && (state == IDLE) && (bus_in[5:4] != 2'b11);
  assign read_start = wr_c && bus_in[0] && (state == IDLE) && !prog_start;
  assign done       = (state == PROG) && (busy_cnt == BW'(1));
  assign int_out    = eerie & ~eepe;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (prog_start) state_nx = PROG;
            else if (read_start) state_nx = READ;
      PROG: if (done) state_nx = IDLE;
      READ: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    case (eepm)
      2'b00:   new_byte = eedr;
      2'b01:   new_byte = 8'hFF;
      2'b10:   new_byte = mem_q & eedr;
      default: new_byte = mem_q;
    endcase
  end

  always_comb begin
    bus_out = '0;
    if (rd) begin
      if (addr == BUS_ADDR_DATA_LEN'(EEARH_ADDR))      bus_out = eearh;
      else if (addr == BUS_ADDR_DATA_LEN'(EEARL_ADDR)) bus_out = eearl;
      else if (addr == BUS_ADDR_DATA_LEN'(EEDR_ADDR))  bus_out = eedr;
      else if (addr == BUS_ADDR_DATA_LEN'(EECR_ADDR))  bus_out = {2'b00, eepm, eerie, eempe, eepe, eere};
    end
  end

`ifdef ATMEGA_EEP_HOST_PORT_EN
  logic host_go;
  assign host_go = (host_we || host_re) && (state == IDLE) && !wr_c;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      eearh <= '0; eearl <= '0; eedr <= '0;
      eere <= 1'b0; eepe <= 1'b0; eempe <= 1'b0; eerie <= 1'b0; eepm <= '0;
      mpe_cnt <= '0; busy_cnt <= '0; rd_done <= 1'b0; dirty <= 1'b0;
`ifdef ATMEGA_EEP_HOST_PORT_EN
      host_ack <= 1'b0;
`endif
    end else begin
      state   <= state_nx;
      rd_done <= (state == READ);
      if (wr_h && state != PROG) eearh <= bus_in & HMASK;
      if (wr_l && state != PROG) eearl <= bus_in;
      if (rd_done) eedr <= mem_q;
      else if (wr_d && state != PROG) eedr <= bus_in;
      if (wr_c) begin
        eerie <= bus_in[3];
        if (state != PROG) eepm <= bus_in[5:4];
      end
      if (prog_start) begin
        eempe   <= 1'b0;
        mpe_cnt <= '0;
      end else if (wr_c && bus_in[2]) begin
        eempe   <= 1'b1;
        mpe_cnt <= 3'd4;
      end else if (mpe_cnt != '0) begin
        mpe_cnt <= mpe_cnt - 3'd1;
        if (mpe_cnt == 3'd1) eempe <= 1'b0;
      end
      if (prog_start) begin
        eepe     <= 1'b1;
        busy_cnt <= (bus_in[5:4] == 2'b00) ? BW'(WRITE_CYCLES) : BW'(WRITE_CYCLES / 2);
      end else if (state == PROG) begin
        busy_cnt <= busy_cnt - BW'(1);
        if (done) eepe <= 1'b0;
      end
      if (read_start) eere <= 1'b1;
      else if (rd_done) eere <= 1'b0;
      if (done) dirty <= 1'b1;
      else if (dirty_clr) dirty <= 1'b0;
`ifdef ATMEGA_EEP_HOST_PORT_EN
      host_ack <= host_go;
`endif
    end
  end

  // EEAR is frozen during PROG, so mem_q holds the old target byte for the AND mode
  always_ff @(posedge clk) begin
    mem_q <= mem[eear];
    if (done) mem[eear] <= new_byte;
`ifdef ATMEGA_EEP_HOST_PORT_EN
    if (host_go) begin
      if (host_we) mem[host_addr] <= host_din;
      host_dout <= host_we ? host_din : mem[host_addr];
    end
`endif
  end

  initial begin
    for (int unsigned i = 0; i < EEP_SIZE; i++) mem[i] = 8'hFF;
    mem[1] = 8'h06;
    mem[2] = 8'h01;
  end

endmodule
